// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: state encoding and drain-length default shared by the conv tile scheduler
package conv_ctrl_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_MV = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  // A full systolic wavefront needs two array widths to leave the PEs.
  function automatic int drain_default(input int pe_size);
    return 2 * pe_size;
  endfunction
endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: tile index counters and base-address accumulators for the tile walk
//   load_i  : latch counts/bases/strides, clear indices, present the first tile's bases
//   step_i  : advance one tile (row inner, column outer) with incremental adders
//   clear_i : abort, zero the indices and base outputs (wins over load/step)
//   col_idx_o/row_idx_o, mem0_base_o/mem1_base_o : current tile
//   last_o  : current tile is the final one of the grid
module tile_addr_gen #(
  parameter int TCW = 8,
  parameter int A0W = 10,
  parameter int A1W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           clear_i,
  input  logic [TCW-1:0] num_col_i,
  input  logic [TCW-1:0] num_row_i,
  input  logic [A0W-1:0] mem0_base_i,
  input  logic [A1W-1:0] mem1_base_i,
  input  logic [A0W-1:0] mem0_stride_i,
  input  logic [A1W-1:0] mem1_stride_i,
  output logic [TCW-1:0] col_idx_o,
  output logic [TCW-1:0] row_idx_o,
  output logic [A0W-1:0] mem0_base_o,
  output logic [A1W-1:0] mem1_base_o,
  output logic           last_o
);
  logic [TCW-1:0] ncol_q, ncol_d, nrow_q, nrow_d, col_q, col_d, row_q, row_d;
  logic [A0W-1:0] stride0_q, stride0_d, addr0_q, addr0_d;
  logic [A1W-1:0] base1_q, base1_d, stride1_q, stride1_d, addr1_q, addr1_d;
  logic           row_last, col_last;
  assign row_last = row_q == nrow_q - 1'b1;
  assign col_last = col_q == ncol_q - 1'b1;
  assign last_o = row_last && col_last;
  assign col_idx_o = col_q;
  assign row_idx_o = row_q;
  assign mem0_base_o = addr0_q;
  assign mem1_base_o = addr1_q;
  always_comb begin
    ncol_d = ncol_q;
    nrow_d = nrow_q;
    base1_d = base1_q;
    stride0_d = stride0_q;
    stride1_d = stride1_q;
    col_d = col_q;
    row_d = row_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
      addr0_d = '0;
      addr1_d = '0;
    end else if (load_i) begin
      ncol_d = num_col_i;
      nrow_d = num_row_i;
      base1_d = mem1_base_i;
      stride0_d = mem0_stride_i;
      stride1_d = mem1_stride_i;
      col_d = '0;
      row_d = '0;
      addr0_d = mem0_base_i;
      addr1_d = mem1_base_i;
    end else if (step_i) begin
      if (!row_last) begin
        row_d = row_q + 1'b1;
        addr1_d = addr1_q + stride1_q;
      end else begin
        // Row wrap restarts the activation walk from the latched base.
        row_d = '0;
        addr1_d = base1_q;
        if (!col_last) begin
          col_d = col_q + 1'b1;
          addr0_d = addr0_q + stride0_q;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncol_q <= '0;
      nrow_q <= '0;
      base1_q <= '0;
      stride0_q <= '0;
      stride1_q <= '0;
      col_q <= '0;
      row_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
    end else begin
      ncol_q <= ncol_d;
      nrow_q <= nrow_d;
      base1_q <= base1_d;
      stride0_q <= stride0_d;
      stride1_q <= stride1_d;
      col_q <= col_d;
      row_q <= row_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
    end
  end
endmodule

// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: walks the column x row tile grid, issuing one data-mover job per tile
//   start_i/abort_i        : job start (IDLE only) and abort (highest priority)
//   num_*_tiles_i, mem*_i  : grid size, bases and strides, latched at start
//   mv_start_o/mv_done_i   : data-mover handshake; mv_mem*_base_o hold the tile bases
//   sa_clear_o             : accumulator clear, coincident with mv_start_o
//   col_idx_o/row_idx_o    : current tile; busy_o outside IDLE; done_o one-cycle completion
module conv_tile_scheduler
  import conv_ctrl_pkg::*;
#(
  parameter int PE_SIZE         = 16,
  parameter int MEM0_ADDR_WIDTH = 10,
  parameter int MEM1_ADDR_WIDTH = 10,
  parameter int TILE_CNT_WIDTH  = 8,
  parameter int DRAIN_CYCLES    = drain_default(PE_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [TILE_CNT_WIDTH-1:0]  num_col_tiles_i,
  input  logic [TILE_CNT_WIDTH-1:0]  num_row_tiles_i,
  input  logic [MEM0_ADDR_WIDTH-1:0] mem0_base_i,
  input  logic [MEM1_ADDR_WIDTH-1:0] mem1_base_i,
  input  logic [MEM0_ADDR_WIDTH-1:0] mem0_stride_i,
  input  logic [MEM1_ADDR_WIDTH-1:0] mem1_stride_i,
  output logic                       mv_start_o,
  input  logic                       mv_done_i,
  output logic [MEM0_ADDR_WIDTH-1:0] mv_mem0_base_o,
  output logic [MEM1_ADDR_WIDTH-1:0] mv_mem1_base_o,
  output logic                       sa_clear_o,
  output logic [TILE_CNT_WIDTH-1:0]  col_idx_o,
  output logic [TILE_CNT_WIDTH-1:0]  row_idx_o,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          load, step, last, empty;
  assign empty = num_col_tiles_i == '0 || num_row_tiles_i == '0;
  assign load = state_q == S_IDLE && start_i && !abort_i;
  assign step = state_q == S_NEXT && !abort_i;
  // Every output is a decode of state_q, so no input reaches an output combinationally.
  assign mv_start_o = state_q == S_ISSUE;
  assign sa_clear_o = state_q == S_ISSUE;
  assign busy_o = state_q != S_IDLE;
  assign done_o = state_q == S_DONE;
  tile_addr_gen #(
    .TCW(TILE_CNT_WIDTH),
    .A0W(MEM0_ADDR_WIDTH),
    .A1W(MEM1_ADDR_WIDTH)
  ) u_addr (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .step_i       (step),
    .clear_i      (abort_i),
    .num_col_i    (num_col_tiles_i),
    .num_row_i    (num_row_tiles_i),
    .mem0_base_i  (mem0_base_i),
    .mem1_base_i  (mem1_base_i),
    .mem0_stride_i(mem0_stride_i),
    .mem1_stride_i(mem1_stride_i),
    .col_idx_o    (col_idx_o),
    .row_idx_o    (row_idx_o),
    .mem0_base_o  (mv_mem0_base_o),
    .mem1_base_o  (mv_mem1_base_o),
    .last_o       (last)
  );
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (abort_i) begin
      state_d = S_IDLE;
      drain_d = '0;
    end else begin
      case (state_q)
        S_IDLE:    state_d = start_i ? (empty ? S_DONE : S_ISSUE) : S_IDLE;
        S_ISSUE:   state_d = S_WAIT_MV;
        S_WAIT_MV: begin
          state_d = mv_done_i ? S_DRAIN : S_WAIT_MV;
          drain_d = mv_done_i ? DW'(DRAIN_CYCLES - 1) : drain_q;
        end
        S_DRAIN: begin
          state_d = drain_q == '0 ? S_NEXT : S_DRAIN;
          drain_d = drain_q == '0 ? drain_q : drain_q - 1'b1;
        end
        S_NEXT:    state_d = last ? S_DONE : S_ISSUE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// tb_conv_tile_scheduler: directed job table plus hand sequences for abort and spurious inputs
module tb_conv_tile_scheduler;
  localparam int DRAIN = 32;
  localparam int GAP = 1 + 5 + DRAIN + 1;
  typedef struct {
    int ncol, nrow, b0, b1, s0, s1, starts, last0, last1;
  } job_t;
  logic       clk = 0, rst_n = 0, start_i = 0, abort_i = 0;
  logic       auto_done = 0, spur_done = 0, mv_auto = 0;
  logic [7:0] num_col_tiles_i = 0, num_row_tiles_i = 0;
  logic [9:0] mem0_base_i = 0, mem1_base_i = 0, mem0_stride_i = 0, mem1_stride_i = 0;
  logic       mv_done_i, mv_start_o, sa_clear_o, busy_o, done_o;
  logic [9:0] mv_mem0_base_o, mv_mem1_base_o;
  logic [7:0] col_idx_o, row_idx_o;
  int cyc = 0, checks = 0, failures = 0, n_start = 0, n_done = 0, n_busy = 0, done_cyc = 0, cd = 0;
  int st_cyc[256], st_m0[256], st_m1[256], st_c[256], st_r[256], st_clr[256];
  job_t jobs[6];
  assign mv_done_i = auto_done | spur_done;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  conv_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .num_col_tiles_i(num_col_tiles_i), .num_row_tiles_i(num_row_tiles_i),
    .mem0_base_i(mem0_base_i), .mem1_base_i(mem1_base_i),
    .mem0_stride_i(mem0_stride_i), .mem1_stride_i(mem1_stride_i),
    .mv_start_o(mv_start_o), .mv_done_i(mv_done_i),
    .mv_mem0_base_o(mv_mem0_base_o), .mv_mem1_base_o(mv_mem1_base_o),
    .sa_clear_o(sa_clear_o), .col_idx_o(col_idx_o), .row_idx_o(row_idx_o),
    .busy_o(busy_o), .done_o(done_o)
  );
  // Monitor plus mover model: mover answers 5 cycles after each mv_start_o.
  always @(negedge clk) begin
    auto_done = 0;
    if (mv_start_o) begin
      if (n_start < 256) begin
        st_cyc[n_start] = cyc;
        st_m0[n_start] = int'(mv_mem0_base_o);
        st_m1[n_start] = int'(mv_mem1_base_o);
        st_c[n_start] = int'(col_idx_o);
        st_r[n_start] = int'(row_idx_o);
        st_clr[n_start] = int'(sa_clear_o);
      end
      n_start++;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy_o) n_busy++;
    if (mv_auto && mv_start_o) cd = 5;
    else if (cd > 0) begin
      cd--;
      if (cd == 0) auto_done = 1;
    end
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask
  task automatic set_cfg(input job_t j);
    num_col_tiles_i = 8'(j.ncol);
    num_row_tiles_i = 8'(j.nrow);
    mem0_base_i = 10'(j.b0);
    mem1_base_i = 10'(j.b1);
    mem0_stride_i = 10'(j.s0);
    mem1_stride_i = 10'(j.s1);
  endtask
  task automatic scramble_cfg;
    num_col_tiles_i = 8'($urandom);
    num_row_tiles_i = 8'($urandom);
    mem0_base_i = 10'($urandom);
    mem1_base_i = 10'($urandom);
    mem0_stride_i = 10'($urandom);
    mem1_stride_i = 10'($urandom);
  endtask
  task automatic wait_idle(input string nm);
    for (int t = 0; t < 4000 && busy_o; t++) tick;
    chk({nm, "_idle"}, int'(busy_o), 0);
  endtask
  task automatic run_job(input job_t j, input string nm);
    int n0, s0, d0, bz0, got, last;
    set_cfg(j);
    start_i = 1;
    n0 = cyc;
    s0 = n_start;
    d0 = n_done;
    bz0 = n_busy;
    tick;
    start_i = 0;
    scramble_cfg;
    wait_idle(nm);
    got = n_start - s0;
    chk({nm, "_starts"}, got, j.starts);
    chk({nm, "_dones"}, n_done - d0, 1);
    chk({nm, "_busy_cycles"}, n_busy - bz0, j.starts * GAP + 1);
    if (j.starts == 0) chk({nm, "_done_cyc"}, done_cyc, n0 + 1);
    else begin
      chk({nm, "_first_start_cyc"}, st_cyc[s0], n0 + 1);
      for (int k = 0; k < got && k < j.starts; k++) begin
        int c, r;
        c = k / j.nrow;
        r = k % j.nrow;
        chk($sformatf("%s_t%0d_mem0", nm, k), st_m0[s0+k], (j.b0 + c * j.s0) % 1024);
        chk($sformatf("%s_t%0d_mem1", nm, k), st_m1[s0+k], (j.b1 + r * j.s1) % 1024);
        chk($sformatf("%s_t%0d_col", nm, k), st_c[s0+k], c);
        chk($sformatf("%s_t%0d_row", nm, k), st_r[s0+k], r);
        chk($sformatf("%s_t%0d_clear", nm, k), st_clr[s0+k], 1);
        if (k > 0) chk($sformatf("%s_t%0d_gap", nm, k), st_cyc[s0+k] - st_cyc[s0+k-1], GAP);
      end
      last = s0 + j.starts - 1;
      chk({nm, "_last_mem0"}, st_m0[last], j.last0);
      chk({nm, "_last_mem1"}, st_m1[last], j.last1);
      chk({nm, "_done_cyc"}, done_cyc, st_cyc[last] + GAP);
    end
  endtask
  initial begin
    int s0, d0, n0, md;
    jobs[0] = '{2, 3, 'h010, 'h100, 'h040, 'h020, 6, 'h050, 'h140};
    jobs[1] = '{1, 1, 'h123, 'h2AB, 'h011, 'h022, 1, 'h123, 'h2AB};
    jobs[2] = '{0, 3, 'h010, 'h100, 'h040, 'h020, 0, 0, 0};
    jobs[3] = '{1, 2, 'h005, 'h3F0, 'h100, 'h020, 2, 'h005, 'h010};
    jobs[4] = '{3, 0, 'h010, 'h100, 'h040, 'h020, 0, 0, 0};
    jobs[5] = '{2, 2, 'h3E0, 'h000, 'h030, 'h100, 4, 'h010, 'h100};
    tick;
    tick;
    chk("rst_mv_start", int'(mv_start_o), 0);
    chk("rst_sa_clear", int'(sa_clear_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_mem0", int'(mv_mem0_base_o), 0);
    chk("rst_mem1", int'(mv_mem1_base_o), 0);
    chk("rst_col", int'(col_idx_o), 0);
    chk("rst_row", int'(row_idx_o), 0);
    rst_n = 1;
    tick;
    s0 = n_start;
    spur_done = 1;
    tick;
    spur_done = 0;
    tick;
    chk("idle_spur_busy", int'(busy_o), 0);
    chk("idle_spur_starts", n_start - s0, 0);
    set_cfg(jobs[1]);
    start_i = 1;
    abort_i = 1;
    tick;
    start_i = 0;
    abort_i = 0;
    tick;
    tick;
    chk("abort_start_busy", int'(busy_o), 0);
    chk("abort_start_starts", n_start - s0, 0);
    mv_auto = 1;
    for (int i = 0; i < 6; i++) run_job(jobs[i], $sformatf("job%0d", i));
    mv_auto = 0;
    set_cfg('{1, 1, 'h02A, 'h155, 0, 0, 1, 0, 0});
    s0 = n_start;
    d0 = n_done;
    start_i = 1;
    n0 = cyc;
    tick;
    start_i = 0;
    chk("man_issue_cyc", cyc, n0 + 1);
    chk("man_mv_start", int'(mv_start_o), 1);
    chk("man_sa_clear", int'(sa_clear_o), 1);
    chk("man_mem0", int'(mv_mem0_base_o), 'h02A);
    chk("man_mem1", int'(mv_mem1_base_o), 'h155);
    spur_done = 1;
    tick;
    spur_done = 0;
    start_i = 1;
    tick;
    start_i = 0;
    repeat (5) tick;
    chk("man_wait_starts", n_start - s0, 1);
    chk("man_wait_busy", int'(busy_o), 1);
    spur_done = 1;
    md = cyc;
    tick;
    spur_done = 0;
    repeat (5) tick;
    spur_done = 1;
    start_i = 1;
    tick;
    spur_done = 0;
    start_i = 0;
    wait_idle("man");
    chk("man_done_cyc", done_cyc, md + DRAIN + 2);
    chk("man_starts", n_start - s0, 1);
    chk("man_dones", n_done - d0, 1);
    mv_auto = 1;
    set_cfg(jobs[0]);
    s0 = n_start;
    d0 = n_done;
    start_i = 1;
    tick;
    start_i = 0;
    for (int t = 0; t < 500 && n_start - s0 < 2; t++) tick;
    chk("abort_reach_tile2", n_start - s0, 2);
    repeat (10) tick;
    abort_i = 1;
    tick;
    abort_i = 0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_col", int'(col_idx_o), 0);
    chk("abort_row", int'(row_idx_o), 0);
    chk("abort_mem0", int'(mv_mem0_base_o), 0);
    chk("abort_mem1", int'(mv_mem1_base_o), 0);
    repeat (50) tick;
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_no_start", n_start - s0, 2);
    run_job(jobs[0], "rerun");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
